// File: rtl/hazard_pipe_tracker.sv
// Stall application and E/M/W write-back metadata tracking for the 5-stage core.
// Optional stall-cycle counter enabled by HAZARD_PIPE_TRACKER_STALL_COUNT_EN.
module hazard_pipe_tracker #(
    parameter int unsigned MAX_STALL = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic [2:0]  Res_D,
    input  logic [4:0]  A3_D,
    output logic        en_PC,
    output logic        en_FD,
    output logic        clr_DE,
    output logic [2:0]  Res_E,
    output logic [2:0]  Res_M,
    output logic [2:0]  Res_W,
    output logic [4:0]  A3_E,
    output logic [4:0]  A3_M,
    output logic [4:0]  A3_W,
    output logic        stall_timeout,
    output logic [31:0] stall_cnt
);

    localparam logic [2:0] RES_NW   = 3'b000;
    localparam logic [2:0] RES_ALU  = 3'b001;
    localparam logic [2:0] RES_DM   = 3'b010;
    localparam logic [2:0] RES_PC   = 3'b011;
    localparam logic [2:0] RES_MOVZ = 3'b100;

    localparam logic [3:0] RUN_MAX  = 4'(MAX_STALL);
    localparam logic [3:0] RUN_TRIP = 4'(MAX_STALL - 1);

    logic       d_class_legal;
    logic       d_live;
    logic [2:0] res_e_next;
    logic [4:0] a3_e_next;
    logic [3:0] run_len;

    always_comb begin
        en_PC  = ~Stall;
        en_FD  = ~Stall;
        clr_DE = Stall;
    end

    // $0 is never a live destination, and illegal classes collapse to NW.
    always_comb begin
        d_class_legal = 1'b0;
        case (Res_D)
            RES_ALU, RES_DM, RES_PC, RES_MOVZ: d_class_legal = 1'b1;
            default:                           d_class_legal = 1'b0;
        endcase
        d_live = d_class_legal && (A3_D != 5'd0) && !Stall;
        if (d_live) begin
            res_e_next = Res_D;
            a3_e_next  = A3_D;
        end else begin
            res_e_next = RES_NW;
            a3_e_next  = 5'd0;
        end
    end

    // E/M/W advance every cycle; a stall only injects a bubble into E.
    always_ff @(posedge clk) begin
        if (reset) begin
            Res_E <= RES_NW;
            Res_M <= RES_NW;
            Res_W <= RES_NW;
            A3_E  <= 5'd0;
            A3_M  <= 5'd0;
            A3_W  <= 5'd0;
        end else begin
            Res_E <= res_e_next;
            A3_E  <= a3_e_next;
            Res_M <= Res_E;
            A3_M  <= A3_E;
            Res_W <= Res_M;
            A3_W  <= A3_M;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_len <= 4'd0;
        end else if (Stall) begin
            if (run_len != RUN_MAX) begin
                run_len <= run_len + 4'd1;
            end
        end else begin
            run_len <= 4'd0;
        end
    end

    // Sticky until reset so software can see a deadlock after it clears.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_timeout <= 1'b0;
        end else if (Stall && (run_len == RUN_TRIP)) begin
            stall_timeout <= 1'b1;
        end
    end

`ifdef HAZARD_PIPE_TRACKER_STALL_COUNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
        end else if (Stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule
